// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared encodings for the iterative multiply/divide unit: the 3-bit op
// codes driven by the MIPS control decoder, the FSM state type, and small
// decode helpers so the unit and the decoder agree on one definition.
// No ports (package).
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Multiply and divide ops all sit in the lower half of the op space.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// ---------------------------------------------------------------------------
// muldiv_signfix
// Combinational sign handling around the unsigned iterative core.
//   Start side : srca/srcb + signed_op -> mag_a/mag_b (absolute values) and
//                neg_a/neg_b (operand was negative, signed ops only).
//   FIX side   : raw (unsigned core result, quotient/remainder packed as
//                {rem, quot} for divides), div_mode and the latched operand
//                signs flip_a/flip_b -> res_hi/res_lo with signs applied.
// ---------------------------------------------------------------------------
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    input  logic               signed_op,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic               neg_a,
    output logic               neg_b,
    input  logic [2*WIDTH-1:0] raw,
    input  logic               div_mode,
    input  logic               flip_a,
    input  logic               flip_b,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo
);

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               flip_q;

    // Operand magnitudes. The most-negative value maps onto itself, which
    // is still its correct unsigned magnitude.
    always_comb begin
        neg_a = signed_op & srca[WIDTH-1];
        neg_b = signed_op & srcb[WIDTH-1];
        mag_a = neg_a ? (~srca + 1'b1) : srca;
        mag_b = neg_b ? (~srcb + 1'b1) : srcb;
    end

    // Product and quotient are negative when the signs differ; the
    // remainder follows the dividend (truncating division).
    always_comb begin
        flip_q   = flip_a ^ flip_b;
        prod_fix = flip_q ? (~raw + 1'b1) : raw;
        quot_fix = flip_q ? (~raw[WIDTH-1:0] + 1'b1) : raw[WIDTH-1:0];
        rem_fix  = flip_a ? (~raw[2*WIDTH-1:WIDTH] + 1'b1) : raw[2*WIDTH-1:WIDTH];
        if (div_mode) begin
            res_hi = rem_fix;
            res_lo = quot_fix;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit with the architectural HI/LO registers.
// One result bit per clock: WIDTH iteration edges after the start edge,
// then a FIX edge that applies signs and writes hi/lo.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, op         request and operation (see muldiv_pkg), taken only
//                     while busy=0
//   srca, srcb        operands (srca is also the MTHI/MTLO source)
//   busy              operation in flight
//   done              one-cycle pulse when hi/lo carry a new result
//   dz                divide-by-zero flag of the last completed divide
//   hi, lo            HI and LO registers
// ---------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state;
    logic [CNTW-1:0]    count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   oper;
    logic [WIDTH-1:0]   orig_a;
    logic               div_mode;
    logic               flip_a;
    logic               flip_b;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic               div_zero;

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .srca      (srca),
        .srcb      (srcb),
        .signed_op (is_signed_op(op)),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .neg_a     (neg_a),
        .neg_b     (neg_b),
        .raw       (acc),
        .div_mode  (div_mode),
        .flip_a    (flip_a),
        .flip_b    (flip_b),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    // One iteration of either algorithm on the shared accumulator.
    // Multiply: acc = {partial, multiplier}; add the multiplicand into the
    // upper half when the multiplier LSB is set, then shift right.
    // Divide: acc = {remainder, dividend/quotient}; shift left one bit and
    // keep the trial subtraction only when it does not borrow. Because the
    // remainder stays below the divisor, the borrow shows up as bit WIDTH
    // of the trial difference.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, oper} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, oper};
        div_ge    = ~div_trial[WIDTH];
        div_rem   = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        if (div_mode) begin
            acc_next = {div_rem, acc[WIDTH-2:0], div_ge};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
        div_zero = div_mode && (oper == '0);
    end

    // Control FSM with registered handshake outputs. The operand register
    // holds whichever value is added/subtracted each iteration (multiplicand
    // or divisor); the other operand seeds the low half of the accumulator.
    // A zero divisor still runs the full iteration count so latency never
    // depends on the data; its result is substituted at FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
            acc      <= '0;
            oper     <= '0;
            orig_a   <= '0;
            div_mode <= 1'b0;
            flip_a   <= 1'b0;
            flip_b   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_arith_op(op)) begin
                            div_mode <= is_div_op(op);
                            flip_a   <= neg_a;
                            flip_b   <= neg_b;
                            orig_a   <= srca;
                            oper     <= is_div_op(op) ? mag_b : mag_a;
                            acc      <= {{WIDTH{1'b0}}, (is_div_op(op) ? mag_a : mag_b)};
                            count    <= '0;
                            busy     <= 1'b1;
                            state    <= RUN;
                        end else if (op == OP_MTHI) begin
                            hi   <= srca;
                            done <= 1'b1;
                        end else if (op == OP_MTLO) begin
                            lo   <= srca;
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count + CNTW'(1);
                    if (count == CNTW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (div_zero) begin
                        hi <= orig_a;
                        lo <= '1;
                        dz <= 1'b1;
                    end else begin
                        hi <= res_hi;
                        lo <= res_lo;
                        if (div_mode) begin
                            dz <= 1'b0;
                        end
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
